// File: rtl/lpf_pkg.sv
// rtl/lpf_pkg.sv - shared defaults, widths and rounding helper for the decimator output stage
package lpf_pkg;

    localparam int WORD_IN_DEF    = 18;
    localparam int WORD_OUT_DEF   = 8;
    localparam int DECIM_DEF      = 4;
    localparam int SHIFT_DEF      = 10;
    localparam int FIFO_DEPTH_DEF = 4;

    // A one-entry phase counter still needs a one-bit register.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PHASE_W = width_of(DECIM_DEF);
    localparam int PTR_W   = width_of(FIFO_DEPTH_DEF);

    typedef struct packed {
        logic        sat;
        logic [63:0] q;
    } sat_round_t;

    // Round half-up, shift right, clamp to an unsigned word_out-bit range.
    // 64-bit arithmetic keeps the rounding add from wrapping for any WORD_IN used here.
    function automatic sat_round_t sat_round(input logic [63:0] value,
                                             input int          shift,
                                             input int          word_out);
        logic [63:0] rnd;
        logic [63:0] q;
        logic [63:0] max_v;
        sat_round_t  r;
        rnd   = value + (64'd1 << (shift - 1));
        q     = rnd >> shift;
        max_v = (64'd1 << word_out) - 64'd1;
        r.sat = (q > max_v);
        r.q   = r.sat ? max_v : q;
        return r;
    endfunction

endpackage

// File: rtl/lpf_decimator_out_if.sv
// rtl/lpf_decimator_out_if.sv - valid/ready output sample interface
interface lpf_decimator_out_if #(
    parameter int WORD_OUT = 8
);
    logic [WORD_OUT-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/lpf_out_fifo.sv
// rtl/lpf_out_fifo.sv - synchronous fall-through FIFO with push/pop/full/empty/count
module lpf_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];

    // A push into a full FIFO only lands when a pop frees the head slot the same cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Storage, power-of-two wrapping pointers and occupancy count.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/lpf_decimator_out.sv
// rtl/lpf_decimator_out.sv - decimate, round/saturate and buffer FIR output samples
module lpf_decimator_out
    import lpf_pkg::*;
#(
    parameter int WORD_IN    = WORD_IN_DEF,
    parameter int WORD_OUT   = WORD_OUT_DEF,
    parameter int DECIM      = DECIM_DEF,
    parameter int SHIFT      = SHIFT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [WORD_IN-1:0]  data_in,
    input  logic                ovf_clr,
    output logic                overflow,
    output logic                sat_flag,
    lpf_decimator_out_if.master out_if
);

    localparam int PH_W = width_of(DECIM);
    localparam int P_W  = width_of(FIFO_DEPTH);

    logic [PH_W-1:0]     phase;
    logic                keep;
    sat_round_t          sr;
    logic [WORD_OUT-1:0] stage;
    logic                stage_valid;
    logic                pop;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [P_W:0]        fifo_count;
    logic                unused_bits;

    assign keep = sample_en && (phase == '0);
    assign sr   = sat_round({{(64-WORD_IN){1'b0}}, data_in}, SHIFT, WORD_OUT);
    assign pop  = out_if.out_valid && out_if.out_ready;
    assign drop = stage_valid && fifo_full && !pop;

    assign unused_bits = &{1'b0, sr.q[63:WORD_OUT], fifo_count};

    // Phase counter: advances only on new filter samples, wraps at DECIM-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= '0;
        end else if (sample_en) begin
            phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
        end
    end

    // Rounding stage: registers the saturated result of each kept sample for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage       <= '0;
            stage_valid <= 1'b0;
        end else begin
            stage_valid <= keep;
            if (keep) begin
                stage <= sr.q[WORD_OUT-1:0];
            end
        end
    end

    // Sticky status flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (keep && sr.sat) begin
                sat_flag <= 1'b1;
            end else if (ovf_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

    lpf_out_fifo #(
        .WIDTH (WORD_OUT),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (P_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (stage_valid),
        .push_data (stage),
        .pop       (pop),
        .pop_data  (out_if.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_if.out_valid = !fifo_empty;

endmodule

// File: tb/tb_lpf_decimator_out.sv
// tb/tb_lpf_decimator_out.sv - directed self-checking bench for lpf_decimator_out
module tb_lpf_decimator_out;

    logic        clock;
    logic        reset;
    logic        sample_en;
    logic [17:0] data_in;
    logic        ovf_clr;
    logic        overflow;
    logic        sat_flag;

    int tests_run;
    int tests_failed;

    lpf_decimator_out_if #(.WORD_OUT(8)) bus ();

    lpf_decimator_out #(
        .WORD_IN    (18),
        .WORD_OUT   (8),
        .DECIM      (4),
        .SHIFT      (10),
        .FIFO_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sample_en (sample_en),
        .data_in   (data_in),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow),
        .sat_flag  (sat_flag),
        .out_if    (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        sample_en = 1'b0;
        ovf_clr   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // One kept sample followed by three discarded ones; output checked two cycles after the keep.
    task automatic run_keep(input logic [17:0] d, input logic [7:0] exp, input string tag);
        sample_en = 1'b1;
        data_in   = d;
        tick();
        data_in = '0;
        tick();
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp));
        tick();
        tick();
        sample_en = 1'b0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        data_in       = '0;
        bus.out_ready = 1'b0;
        do_reset();

        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);

        // Continuous samples: value (1536+512)>>10 = 2 every fourth cycle.
        bus.out_ready = 1'b1;
        sample_en     = 1'b1;
        data_in       = 18'd1536;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("cont_valid", 32'(bus.out_valid), ((i + 1) % 4 == 2) ? 32'd1 : 32'd0);
            if ((i + 1) % 4 == 2) check("cont_data", 32'(bus.out_data), 32'd2);
        end
        check("cont_ovf", 32'(overflow), 32'd0);

        // Saturation and rounding boundaries.
        do_reset();
        bus.out_ready = 1'b1;
        run_keep(18'h3FFFF, 8'hFF, "sat_max");
        check("sat_set", 32'(sat_flag), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("sat_clr", 32'(sat_flag), 32'd0);
        run_keep(18'd1535, 8'd1, "r1535");
        run_keep(18'd511, 8'd0, "r511");
        run_keep(18'd512, 8'd1, "r512");
        run_keep(18'd261631, 8'd255, "r255_edge");
        check("sat_none", 32'(sat_flag), 32'd0);
        run_keep(18'd261632, 8'd255, "r256_edge");
        check("sat_edge", 32'(sat_flag), 32'd1);

        // Back-pressure: four keeps fill the FIFO, the fifth (value 16) is dropped.
        do_reset();
        bus.out_ready = 1'b0;
        sample_en     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = 18'(1024 * i);
            tick();
        end
        sample_en = 1'b0;
        check("full_ovf", 32'(overflow), 32'd1);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("drain_valid", 32'(bus.out_valid), 32'd1);
            check("drain_data", 32'(bus.out_data), 32'(4 * j));
            tick();
        end
        check("drain_empty", 32'(bus.out_valid), 32'd0);
        check("drain_ovf", 32'(overflow), 32'd1);

        // Full FIFO with a pop in the write cycle: both happen, no overflow.
        do_reset();
        bus.out_ready = 1'b0;
        sample_en     = 1'b1;
        for (int i = 0; i < 17; i++) begin
            data_in = 18'(1024 * i);
            tick();
        end
        sample_en     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("pp_ovf", 32'(overflow), 32'd0);
        bus.out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            check("pp_valid", 32'(bus.out_valid), 32'd1);
            check("pp_data", 32'(bus.out_data), 32'(4 * j));
            tick();
        end
        check("pp_empty", 32'(bus.out_valid), 32'd0);

        // Gapped sample_en: keeps only on samples 0, 4, 8.
        do_reset();
        bus.out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            sample_en = 1'b1;
            data_in   = 18'(1024 * n);
            tick();
            sample_en = 1'b0;
            tick();
            check("gap_valid", 32'(bus.out_valid), (n % 4 == 0) ? 32'd1 : 32'd0);
            if (n % 4 == 0) check("gap_data", 32'(bus.out_data), 32'(n));
            tick();
        end

        // Reset with three entries stored and a sample in the stage register.
        do_reset();
        bus.out_ready = 1'b0;
        sample_en     = 1'b1;
        for (int i = 0; i < 13; i++) begin
            data_in = 18'(1024 * i);
            tick();
        end
        reset     = 1'b1;
        sample_en = 1'b0;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        tick();
        check("mid_rst_stale", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        run_keep(18'd5120, 8'd5, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
